// File: rtl/cereal_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM, framing-error/break handling.
// Optional ASCII-to-switch-code decoder enabled by defining CEREAL_RX_DECODE_EN.
module cereal_rx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy,
  output logic [3:0] digit,
  output logic       digit_ok
);

  localparam logic [15:0] CPB_M1  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_M1 = 16'((CLKS_PER_BIT / 2) - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t      state_r, state_s;
  logic        rx_meta_r, rx_sync_r, rx_s;
  logic [15:0] cnt_r, cnt_s;
  logic [2:0]  idx_r, idx_s;
  logic [7:0]  shift_r, shift_s;
  logic [7:0]  data_r, data_s;
  logic        valid_r, valid_s;
  logic        ferr_r, ferr_s;
  logic        busy_r, busy_s;

  assign rx_s = rx_sync_r;

  // Synchronizer, FSM state, counters and registered outputs.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      state_r   <= IDLE;
      cnt_r     <= 16'd0;
      idx_r     <= 3'd0;
      shift_r   <= 8'h00;
      data_r    <= 8'h00;
      valid_r   <= 1'b0;
      ferr_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      idx_r     <= idx_s;
      shift_r   <= shift_s;
      data_r    <= data_s;
      valid_r   <= valid_s;
      ferr_r    <= ferr_s;
      busy_r    <= busy_s;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
    shift_s = shift_r;
    data_s  = data_r;
    valid_s = 1'b0;
    ferr_s  = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_s = 16'd0;
        idx_s = 3'd0;
        if (!rx_s) state_s = START;
        else       state_s = IDLE;
      end
      START: begin
        if (cnt_r == HALF_M1) begin
          cnt_s = 16'd0;
          // A high mid-start sample means the falling edge was a glitch.
          if (rx_s) state_s = IDLE;
          else      state_s = DATA;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      DATA: begin
        if (cnt_r == CPB_M1) begin
          cnt_s          = 16'd0;
          shift_s[idx_r] = rx_s;
          if (idx_r == 3'd7) begin
            idx_s   = 3'd0;
            state_s = STOP;
          end else begin
            idx_s = idx_r + 3'd1;
          end
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      STOP: begin
        if (cnt_r == CPB_M1) begin
          cnt_s = 16'd0;
          if (rx_s) begin
            data_s  = shift_r;
            valid_s = 1'b1;
            state_s = IDLE;
          end else begin
            ferr_s  = 1'b1;
            state_s = BREAK;
          end
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      BREAK: begin
        // Hold off until the line idles so a stuck-low rx cannot retrigger.
        if (rx_s) state_s = IDLE;
        else      state_s = BREAK;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  assign data      = data_r;
  assign valid     = valid_r;
  assign frame_err = ferr_r;
  assign busy      = busy_r;

`ifdef CEREAL_RX_DECODE_EN
  function automatic logic [4:0] decode_ascii(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) begin
      decode_ascii = {1'b1, c[3:0]};
    end else if (c == 8'h55) begin
      decode_ascii = {1'b1, 4'hF};
    end else begin
      decode_ascii = 5'h00;
    end
  endfunction

  assign {digit_ok, digit} = decode_ascii(data_r);
`else
  assign digit    = 4'h0;
  assign digit_ok = 1'b0;
`endif

endmodule

// File: tb/tb_cereal_rx.sv
// Directed bench for cereal_rx at CLKS_PER_BIT=16: timing, glitch, framing error, reset, decode.
module tb_cereal_rx;
  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  localparam int VLAT = 3 + HALF + 9 * CPB;

`ifdef CEREAL_RX_DECODE_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif

  logic       sysclk = 1'b0;
  logic       rst_n  = 1'b0;
  logic       rx     = 1'b1;
  logic [7:0] data;
  logic       valid, frame_err, busy, digit_ok;
  logic [3:0] digit;

  int checks = 0, failures = 0;
  int cyc = 0, fall_cyc = 0, rx_rise_cyc = 0;
  int valid_cnt = 0, valid_cyc = 0, ferr_cnt = 0, ferr_cyc = 0;
  int rise_cnt = 0, rise_cyc = 0, busy_fall_cyc = 0;
  int v0, f0, r0;
  logic       busy_q = 1'b0;
  logic [7:0] cap_data = 8'h00;
  logic [3:0] cap_digit = 4'h0;
  logic       cap_ok = 1'b0;

  cereal_rx #(.CLKS_PER_BIT(CPB)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .rx(rx), .data(data), .valid(valid),
    .frame_err(frame_err), .busy(busy), .digit(digit), .digit_ok(digit_ok)
  );

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) cyc <= cyc + 1;

  always @(negedge sysclk) begin
    if (valid) begin
      valid_cnt = valid_cnt + 1;
      valid_cyc = cyc;
      cap_data  = data;
      cap_digit = digit;
      cap_ok    = digit_ok;
    end
    if (frame_err) begin
      ferr_cnt = ferr_cnt + 1;
      ferr_cyc = cyc;
    end
    if (busy && !busy_q) begin
      rise_cnt = rise_cnt + 1;
      rise_cyc = cyc;
    end
    if (!busy && busy_q) busy_fall_cyc = cyc;
    busy_q = busy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    fall_cyc = cyc;
    repeat (CPB) @(negedge sysclk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge sysclk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge sysclk);
  endtask

  initial begin
    @(negedge sysclk);
    repeat (3) @(negedge sysclk);
    chk("rst_data", 32'(data), 32'h00);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_ferr", 32'(frame_err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_digit", 32'(digit), 32'h0);
    chk("rst_digit_ok", 32'(digit_ok), 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge sysclk);

    // Single frame 0x35
    send_frame(8'h35, 1'b1);
    chk("f1_valid_cnt", 32'(valid_cnt), 32'd1);
    chk("f1_valid_lat", 32'(valid_cyc - fall_cyc), 32'(VLAT));
    chk("f1_busy_rise", 32'(rise_cyc - fall_cyc), 32'd3);
    chk("f1_busy_fall", 32'(busy_fall_cyc), 32'(valid_cyc));
    chk("f1_data", 32'(cap_data), 32'h35);
    chk("f1_digit", 32'(cap_digit), DEC ? 32'h5 : 32'h0);
    chk("f1_digit_ok", 32'(cap_ok), DEC ? 32'h1 : 32'h0);
    chk("f1_ferr_cnt", 32'(ferr_cnt), 32'd0);

    // Back-to-back 0x55, 0x41
    send_frame(8'h55, 1'b1);
    chk("f2_valid_cnt", 32'(valid_cnt), 32'd2);
    chk("f2_data", 32'(cap_data), 32'h55);
    chk("f2_digit", 32'(cap_digit), DEC ? 32'hF : 32'h0);
    chk("f2_digit_ok", 32'(cap_ok), DEC ? 32'h1 : 32'h0);
    send_frame(8'h41, 1'b1);
    chk("f3_valid_cnt", 32'(valid_cnt), 32'd3);
    chk("f3_valid_lat", 32'(valid_cyc - fall_cyc), 32'(VLAT));
    chk("f3_data", 32'(cap_data), 32'h41);
    chk("f3_digit", 32'(cap_digit), 32'h0);
    chk("f3_digit_ok", 32'(cap_ok), 32'h0);
    repeat (CPB) @(negedge sysclk);

    // Short glitch
    v0 = valid_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    fall_cyc = cyc;
    repeat (5) @(negedge sysclk);
    rx = 1'b1;
    repeat (40) @(negedge sysclk);
    chk("gl_valid_cnt", 32'(valid_cnt), 32'(v0));
    chk("gl_ferr_cnt", 32'(ferr_cnt), 32'(f0));
    chk("gl_busy_fall", 32'(busy_fall_cyc - fall_cyc), 32'(3 + HALF));
    chk("gl_busy", 32'(busy), 32'h0);

    // Framing error then held-low line
    v0 = valid_cnt; r0 = rise_cnt;
    send_frame(8'h33, 1'b0);
    chk("fe_ferr_cnt", 32'(ferr_cnt), 32'(f0 + 1));
    chk("fe_ferr_lat", 32'(ferr_cyc - fall_cyc), 32'(VLAT));
    repeat (40) @(negedge sysclk);
    chk("fe_busy_hold", 32'(busy), 32'h1);
    rx = 1'b1;
    rx_rise_cyc = cyc;
    repeat (40) @(negedge sysclk);
    chk("fe_busy_fall", 32'(busy_fall_cyc - rx_rise_cyc), 32'd3);
    chk("fe_valid_cnt", 32'(valid_cnt), 32'(v0));
    chk("fe_ferr_once", 32'(ferr_cnt), 32'(f0 + 1));
    chk("fe_no_retrig", 32'(rise_cnt), 32'(r0 + 1));
    chk("fe_data_kept", 32'(data), 32'h41);

    // Reset mid-DATA of 0x37
    v0 = valid_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    repeat (CPB) @(negedge sysclk);
    for (int i = 0; i < 2; i++) begin
      rx = 1'b1;
      repeat (CPB) @(negedge sysclk);
    end
    rx = 1'b1;
    repeat (HALF) @(negedge sysclk);
    rst_n = 1'b0;
    @(negedge sysclk);
    rst_n = 1'b1;
    chk("mr_busy", 32'(busy), 32'h0);
    chk("mr_data", 32'(data), 32'h00);
    chk("mr_valid", 32'(valid), 32'h0);
    chk("mr_ferr", 32'(frame_err), 32'h0);
    chk("mr_digit", 32'(digit), 32'h0);
    chk("mr_digit_ok", 32'(digit_ok), 32'h0);
    repeat (12 * CPB) @(negedge sysclk);
    chk("mr_no_valid", 32'(valid_cnt), 32'(v0));
    chk("mr_no_ferr", 32'(ferr_cnt), 32'(f0));
    send_frame(8'h32, 1'b1);
    chk("mr_post_cnt", 32'(valid_cnt), 32'(v0 + 1));
    chk("mr_post_data", 32'(cap_data), 32'h32);
    chk("mr_post_digit", 32'(cap_digit), DEC ? 32'h2 : 32'h0);

    // 0x39 decode
    send_frame(8'h39, 1'b1);
    chk("d9_data", 32'(cap_data), 32'h39);
    chk("d9_digit", 32'(cap_digit), DEC ? 32'h9 : 32'h0);
    chk("d9_digit_ok", 32'(cap_ok), DEC ? 32'h1 : 32'h0);
    repeat (CPB) @(negedge sysclk);
    chk("d9_hold_digit", 32'(digit), DEC ? 32'h9 : 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cereal_rx.md
# cereal_rx

UART receiver on the PC-to-board side of the serial link, and the inverse of the keyboard/cereal transmit path. Takes the asynchronous `rx` line and recovers 8N1 frames (LSB first). Presents each good byte with a one-cycle `valid` strobe and flags bad stop bits. An optional decoder maps the ASCII characters the keyboard path produces back to the 4-bit switch code, for driving LEDs/7-seg on the receiving board.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 5208: sysclk cycles per bit (50 MHz / 9600 baud); legal range 4..65535.

Ports:
- `sysclk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset, synchronous, active-low.
- `rx`  in  1  serial line; idle high; asynchronous to `sysclk`.
- `data`  out  8  last good received byte.
- `valid`  out  1  one-cycle pulse; `data` updated in the same cycle.
- `frame_err`  out  1  one-cycle pulse on a bad stop bit.
- `busy`  out  1  high in every state except IDLE.
- `digit`  out  4  decoded switch code of `data`.
- `digit_ok`  out  1  `digit` is a legal decode.

## Operation
- `rx` passes through a 2-flop synchronizer; both flops reset to 1. `rx_s` is the synchronizer output.
- `HALF = CLKS_PER_BIT/2` (integer division). The bit counter is 16 bits wide and the bit index is 3 bits wide.
- FSM states and transitions:
  - IDLE: go to START when `rx_s`=0.
  - START: count HALF cycles, then sample `rx_s`. If the sample is 1, it was a glitch; return to IDLE with no output. If 0, clear the counter and go to DATA.
  - DATA: every CLKS_PER_BIT cycles, sample `rx_s` into shift bit[index] (LSB first). After bit 7, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample `rx_s`.
    - If 1: load `data`, pulse `valid`, go to IDLE.
    - If 0: pulse `frame_err`, leave `data` unchanged, go to BREAK.
  - BREAK: wait for `rx_s`=1, then go to IDLE. This prevents a held-low line from retriggering reception.
- From IDLE, a new falling edge is accepted in the cycle after returning to IDLE. Back-to-back frames with a full 1-bit stop are received without loss.
- Decode (when enabled), applied combinationally from `data`:
  - 0x30..0x39 → `digit` = 0..9, `digit_ok`=1.
  - 0x55 ('U') → `digit` = 4'hF, `digit_ok`=1.
  - Any other value → `digit`=0, `digit_ok`=0.
- Reset values: `data`=8'h00, `valid`=0, `frame_err`=0, `busy`=0, FSM=IDLE, counters=0, `digit`=0, `digit_ok`=0. `data`=0x00 does not decode, so `digit_ok` stays 0 after reset.
- `rst_n` low on any edge returns the block to IDLE in the next cycle, from any state. A partial frame is discarded, with no `valid` or `frame_err` pulse.

## Timing
- Let t0 be the first cycle `rx_s`=0 is seen in IDLE, i.e. 2 cycles after the line falls.
- Sample points:
  - start bit: t0+HALF
  - data bit i: t0+HALF+(i+1)·CLKS_PER_BIT
  - stop bit: t0+HALF+9·CLKS_PER_BIT
- `valid`/`frame_err` are registered: high for exactly one cycle, at stop sample +1.
- `busy` rises at t0+1. It falls in the same cycle as `valid`; after a framing error it falls one cycle after `rx_s` returns high.
- `digit`/`digit_ok` are valid in the same cycle as `valid` and hold until the next `valid`.
- Tolerates ±4 % baud mismatch at CLKS_PER_BIT ≥ 16.

## Configuration
- `CEREAL_RX_DECODE_EN` defined: the ASCII→switch-code decoder is built and drives `digit`/`digit_ok` as above.
- `CEREAL_RX_DECODE_EN` undefined: no decoder logic; `digit` is tied to 4'h0 and `digit_ok` to 0. Ports remain present.

## Test plan
All scenarios use CLKS_PER_BIT=16.
- Send 0x35 ('5'), 8N1 → one `valid` pulse at stop sample +1; `data`=0x35; with decode enabled, `digit`=4'h5 and `digit_ok`=1.
- Send 0x55 then 0x41 back-to-back, 1 stop bit each → two `valid` pulses; `digit`=F/`digit_ok`=1, then `digit`=0/`digit_ok`=0 with `data`=0x41.
- Pull `rx` low for 5 cycles only → no `valid`, no `frame_err`; `busy` returns low at t0+HALF+1.
- Send 0x33 with stop bit 0, then hold `rx` low for 40 cycles → `frame_err` pulses once; `data` keeps its prior value; `busy` stays high until `rx` rises; no retrigger.
- Assert `rst_n`=0 for 1 cycle mid-DATA during 0x37 → next cycle FSM=IDLE, `busy`=0, all outputs at reset values; the following clean 0x32 is received with `data`=0x32.
- Build without `CEREAL_RX_DECODE_EN` and send 0x39 → `data`=0x39, `digit`=0, `digit_ok`=0.
